// File: rtl/audio_pkg.sv
// audio_pkg: sample width, rate constants and width helper shared by the audio paths
package audio_pkg;
  localparam int SAMPLE_W = 8;
  localparam int CLK_HZ = 100_000_000;
  localparam int SAMPLE_HZ = 8000;
  typedef logic [SAMPLE_W-1:0] sample_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pdm_audio_capture_if.sv
// pdm_audio_capture_if: sample read-out bus between the capture block and its drainer
interface pdm_audio_capture_if
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);
  logic rd_en;
  logic clear_ovf;
  sample_t sample_out;
  logic sample_valid;
  logic overflow;
  logic [clog2(FIFO_DEPTH):0] fifo_count;
  modport master(output rd_en, clear_ovf, input sample_out, sample_valid, overflow, fifo_count);
  modport slave(input rd_en, clear_ovf, output sample_out, sample_valid, overflow, fifo_count);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: first-word fall-through FIFO that drops pushes when full unless a pop frees a slot
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // pop only when data exists; a pop on a full FIFO makes room for a same-cycle push
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    drop = push && !do_push;
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = empty ? '0 : mem_q[rp_q];
    count = cnt_q;
  end
  // storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pdm_audio_capture.sv
// pdm_audio_capture: drives the PDM mic clock, decimates the bit stream by popcount and queues 8-bit samples
module pdm_audio_capture
  import audio_pkg::*;
#(
  parameter int MIC_CLK_HALF = 50,
  parameter int DECIM = 125,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic system_reset,
  input  logic capture_en,
  input  logic pdm_data,
  output logic mic_clk,
  output logic mic_lrsel,
  pdm_audio_capture_if.slave bus
);
  localparam int DIV_W = clog2(MIC_CLK_HALF) > 0 ? clog2(MIC_CLK_HALF) : 1;
  logic [DIV_W-1:0] div_q, div_d;
  logic mic_q, mic_d;
  logic s1_q, s2_q;
  logic [7:0] cnt_q, cnt_d, ones_q, ones_d, cnt_n, ones_n;
  logic [8:0] dbl;
  logic push_q, push_d;
  sample_t smp_q, smp_d, dout;
  logic ovf_q, ovf_d;
  logic tc, fall, win_end, full, empty, drop;
  logic [clog2(FIFO_DEPTH):0] count;
  // bits are taken on the falling mic_clk edge; a full window becomes a saturated 2x popcount
  always_comb begin
    tc = div_q == DIV_W'(MIC_CLK_HALF - 1);
    fall = capture_en && tc && mic_q;
    ones_n = ones_q + 8'(s2_q);
    cnt_n = cnt_q + 8'd1;
    dbl = {ones_n, 1'b0};
    win_end = fall && cnt_n == 8'(DECIM);
    div_d = (!capture_en || tc) ? '0 : div_q + 1'b1;
    mic_d = capture_en && (tc ? !mic_q : mic_q);
    cnt_d = (!capture_en || win_end) ? '0 : fall ? cnt_n : cnt_q;
    ones_d = (!capture_en || win_end) ? '0 : fall ? ones_n : ones_q;
    push_d = win_end;
    smp_d = win_end ? (dbl > 9'd255 ? 8'hff : dbl[7:0]) : smp_q;
    ovf_d = (drop && full) || (ovf_q && !bus.clear_ovf);
  end
  // divider, synchronizer, decimator and overflow state
  always_ff @(posedge clk) begin
    if (system_reset) begin
      div_q <= '0;
      mic_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      ones_q <= '0;
      push_q <= 1'b0;
      smp_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mic_q <= mic_d;
      s1_q <= pdm_data;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      push_q <= push_d;
      smp_q <= smp_d;
      ovf_q <= ovf_d;
    end
  end
  sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(system_reset),
    .push(push_q),
    .din(smp_q),
    .pop(bus.rd_en),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty),
    .drop(drop)
  );
  assign mic_clk = mic_q;
  assign mic_lrsel = 1'b0;
  assign bus.sample_out = dout;
  assign bus.sample_valid = !empty;
  assign bus.fifo_count = count;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pdm_audio_capture.sv
// tb_pdm_audio_capture: directed scenarios checked against a queue-based window/FIFO model every cycle
module tb_pdm_audio_capture;
  localparam int HALF = 4;
  localparam int DECIM = 125;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic system_reset = 1;
  logic capture_en = 0;
  logic pdm_data = 0;
  logic mic_clk, mic_lrsel;
  int tests = 0, fails = 0;
  int mode = 0;
  bit alt = 0, drv_last = 0;
  bit rd_s = 0, clr_s = 0, rst_s = 1, en_s = 0, pdm_s = 0;
  int q[$];
  int cyc = 0, fall_cyc = 0, rise_cyc = -1, wb = 0, wo = 0, pval = 0;
  bit pend = 0, ovf = 0, last_mic = 0, drop = 0;
  int first = 0;

  pdm_audio_capture_if #(.FIFO_DEPTH(DEPTH)) bus ();
  pdm_audio_capture #(.MIC_CLK_HALF(HALF), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .system_reset(system_reset), .capture_en(capture_en), .pdm_data(pdm_data),
    .mic_clk(mic_clk), .mic_lrsel(mic_lrsel), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // microphone stand-in: new bit after each rising mic_clk edge
  always @(negedge clk) begin
    if (mic_clk && !drv_last) begin
      if (mode == 2) begin
        alt = ~alt;
        pdm_data = alt;
      end else pdm_data = (mode == 1);
    end
    drv_last = mic_clk;
  end

  always @(posedge clk) begin
    rd_s = bus.rd_en;
    clr_s = bus.clear_ovf;
    rst_s = system_reset;
    en_s = capture_en;
    pdm_s = pdm_data;
  end

  // model: windows of DECIM bits on falling mic_clk, queue of samples, sticky overflow
  always @(negedge clk) begin
    cyc++;
    drop = 0;
    if (rst_s) begin
      q.delete();
      ovf = 0; pend = 0; wb = 0; wo = 0; rise_cyc = -1;
    end else begin
      if (rd_s && q.size() > 0) void'(q.pop_front());
      if (pend) begin
        if (q.size() < DEPTH) q.push_back(pval);
        else drop = 1;
      end
      ovf = drop ? 1'b1 : clr_s ? 1'b0 : ovf;
      pend = 0;
      if (!en_s) begin
        wb = 0; wo = 0; rise_cyc = -1;
        chk("mic_clk_idle", mic_clk, 0);
      end else if (last_mic && !mic_clk) begin
        wb++;
        wo += pdm_s;
        fall_cyc = cyc;
        if (wb == DECIM) begin
          pend = 1;
          pval = (2 * wo > 255) ? 255 : 2 * wo;
          wb = 0; wo = 0;
        end
      end else if (!last_mic && mic_clk) begin
        if (rise_cyc >= 0) chk("mic_period", cyc - rise_cyc, 2 * HALF);
        rise_cyc = cyc;
      end
    end
    last_mic = mic_clk;
    chk("fifo_count", int'(bus.fifo_count), q.size());
    chk("sample_valid", bus.sample_valid, q.size() > 0);
    chk("sample_out", int'(bus.sample_out), q.size() > 0 ? q[0] : 0);
    chk("overflow", bus.overflow, ovf);
    chk("mic_lrsel", mic_lrsel, 0);
  end

  task automatic drain();
    capture_en = 0;
    bus.rd_en = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!bus.sample_valid) break;
    end
    bus.rd_en = 0;
    chk("drain_empty", bus.sample_valid, 0);
  endtask

  task automatic run_window(input int m, input int exp);
    capture_en = 0;
    repeat (2) @(negedge clk);
    mode = m;
    alt = 0;
    capture_en = 1;
    repeat (1001) @(negedge clk);
    chk("window_count", int'(bus.fifo_count), 1);
    chk("window_sample", int'(bus.sample_out), exp);
  endtask

  initial begin
    bus.rd_en = 0;
    bus.clear_ovf = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_sample", int'(bus.sample_out), 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_mic", mic_clk, 0);
    system_reset = 0;
    @(negedge clk);
    mode = 1;
    capture_en = 1;
    first = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        first = i;
        break;
      end
    end
    #1;
    chk("first_push_latency", first, 1001);
    chk("push_after_fall", cyc - fall_cyc, 1);
    chk("ones_sample", int'(bus.sample_out), 250);
    @(negedge clk);
    drain();
    run_window(0, 0);
    drain();
    run_window(2, 126);
    drain();
    capture_en = 0;
    repeat (2) @(negedge clk);
    mode = 2;
    alt = 0;
    capture_en = 1;
    repeat (17005) @(negedge clk);
    chk("full_count", int'(bus.fifo_count), 16);
    chk("full_ovf", bus.overflow, 1);
    bus.clear_ovf = 1;
    @(negedge clk);
    bus.clear_ovf = 0;
    chk("ovf_cleared", bus.overflow, 0);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      #1;
      if (pend) break;
    end
    chk("pend_seen", pend, 1);
    bus.rd_en = 1;
    @(negedge clk);
    bus.rd_en = 0;
    chk("pushpop_count", int'(bus.fifo_count), 16);
    chk("pushpop_ovf", bus.overflow, 0);
    chk("pushpop_head", int'(bus.sample_out), 124);
    capture_en = 0;
    bus.rd_en = 1;
    repeat (14) @(negedge clk);
    bus.rd_en = 0;
    chk("kept_count", int'(bus.fifo_count), 2);
    mode = 0;
    capture_en = 1;
    repeat (483) @(negedge clk);
    capture_en = 0;
    repeat (20) @(negedge clk);
    chk("paused_count", int'(bus.fifo_count), 2);
    mode = 1;
    capture_en = 1;
    repeat (1001) @(negedge clk);
    chk("resume_count", int'(bus.fifo_count), 3);
    bus.rd_en = 1;
    repeat (2) @(negedge clk);
    bus.rd_en = 0;
    chk("resume_sample", int'(bus.sample_out), 250);
    repeat (4297) @(negedge clk);
    chk("pre_reset_count", int'(bus.fifo_count), 5);
    system_reset = 1;
    @(negedge clk);
    system_reset = 0;
    chk("mid_rst_count", int'(bus.fifo_count), 0);
    chk("mid_rst_valid", bus.sample_valid, 0);
    chk("mid_rst_sample", int'(bus.sample_out), 0);
    chk("mid_rst_mic", mic_clk, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    bus.rd_en = 1;
    @(negedge clk);
    bus.rd_en = 0;
    chk("empty_pop_count", int'(bus.fifo_count), 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
